// File: rtl/neuron_ram_sweeper.sv
// Neuron RAM sweeper: read, offer, collect and write back each word of an inclusive, wrapping address range (NRC_SKIP_INVALID_EN skips Valid=0 words).
// Latency: 5 cycles per word with no stall, plus one DONE cycle per sweep.
// Backpressure: OFFER holds word/address until UpdOutReady; COLLECT waits for UpdInValid; Abort wins everywhere.
module neuron_ram_sweeper #(
    parameter int INTEGER_WIDTH        = 16,
    parameter int DATA_WIDTH_FRAC      = 32,
    parameter int DATA_WIDTH           = INTEGER_WIDTH + DATA_WIDTH_FRAC,
    parameter int TREF_WIDTH           = 8,
    parameter int NEURON_WIDTH_LOGICAL = 11,
    parameter int WORD_WIDTH           = DATA_WIDTH*6 + TREF_WIDTH + 3 + NEURON_WIDTH_LOGICAL + 2,
    parameter int ADDR_WIDTH           = 5
) (
    input  logic                  Clock,
    input  logic                  Reset,
    input  logic                  Start,
    input  logic                  Abort,
    input  logic [ADDR_WIDTH-1:0] FirstAddr,
    input  logic [ADDR_WIDTH-1:0] LastAddr,
    output logic                  Busy,
    output logic                  Done,
    output logic [ADDR_WIDTH:0]   WordCount,
    output logic                  RamChipEnable,
    output logic                  RamWriteEnable,
    output logic [ADDR_WIDTH-1:0] RamAddress,
    output logic [WORD_WIDTH-1:0] RamWriteData,
    input  logic [WORD_WIDTH-1:0] RamReadData,
    output logic                  UpdOutValid,
    input  logic                  UpdOutReady,
    output logic [WORD_WIDTH-1:0] UpdOutWord,
    output logic [ADDR_WIDTH-1:0] UpdOutAddr,
    input  logic                  UpdInValid,
    output logic                  UpdInReady,
    input  logic [WORD_WIDTH-1:0] UpdInWord
);

    typedef enum logic [2:0] {
        S_IDLE, S_READ, S_CAPTURE, S_OFFER, S_COLLECT, S_WRITE, S_DONE
    } state_t;

`ifdef NRC_SKIP_INVALID_EN
    localparam int VALID_BIT = WORD_WIDTH - NEURON_WIDTH_LOGICAL - 1;
`endif

    state_t                state;
    logic [ADDR_WIDTH-1:0] cur;
    logic [ADDR_WIDTH-1:0] last;
    logic [WORD_WIDTH-1:0] word_reg;
    logic [ADDR_WIDTH:0]   word_count;
    logic                  live;
    logic                  ram_slot;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            state      <= S_IDLE;
            cur        <= '0;
            last       <= '0;
            word_reg   <= '0;
            word_count <= '0;
        end else if (Abort && state != S_IDLE) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: begin
                    if (Start) begin
                        cur        <= FirstAddr;
                        last       <= LastAddr;
                        word_count <= '0;
                        state      <= S_READ;
                    end
                end
                S_READ: state <= S_CAPTURE;
                S_CAPTURE: begin
`ifdef NRC_SKIP_INVALID_EN
                    if (!RamReadData[VALID_BIT]) begin
                        if (cur == last) begin
                            state <= S_DONE;
                        end else begin
                            cur   <= cur + ADDR_WIDTH'(1);
                            state <= S_READ;
                        end
                    end else begin
                        word_reg <= RamReadData;
                        state    <= S_OFFER;
                    end
`else
                    word_reg <= RamReadData;
                    state    <= S_OFFER;
`endif
                end
                S_OFFER: begin
                    if (UpdOutReady) state <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (UpdInValid) begin
                        word_reg <= UpdInWord;
                        state    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    word_count <= word_count + (ADDR_WIDTH+1)'(1);
                    // cur wraps naturally at 2^ADDR_WIDTH, giving the wrapping range
                    if (cur == last) begin
                        state <= S_DONE;
                    end else begin
                        cur   <= cur + ADDR_WIDTH'(1);
                        state <= S_READ;
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // Abort suppresses every strobe of the current cycle so no access or handshake completes
    assign live     = ~Abort;
    assign ram_slot = (state == S_READ) || (state == S_WRITE);

    assign Busy           = (state != S_IDLE);
    assign Done           = (state == S_DONE) && live;
    assign WordCount      = word_count;
    assign RamChipEnable  = ram_slot && live;
    assign RamWriteEnable = (state == S_WRITE) && live;
    assign RamAddress     = ram_slot ? cur : '0;
    assign RamWriteData   = (state == S_WRITE) ? word_reg : '0;
    assign UpdOutValid    = (state == S_OFFER) && live;
    assign UpdOutWord     = (state == S_OFFER) ? word_reg : '0;
    assign UpdOutAddr     = (state == S_OFFER) ? cur : '0;
    assign UpdInReady     = (state == S_COLLECT) && live;

endmodule

// File: tb/tb_neuron_ram_sweeper.sv
// Bench for neuron_ram_sweeper: RAM and update-unit models at negedge, scoreboard of expected write-backs.
// Stimulus is driven 1 time unit after the rising edge.
module tb_neuron_ram_sweeper;
    localparam int AW = 5;
    localparam int NW = 11;
    localparam int WW = 48*6 + 8 + 3 + 11 + 2;
    localparam int VB = WW - NW - 1;
    localparam int NA = 32;

    logic          Clock = 1'b0;
    logic          Reset = 1'b1;
    logic          Start = 1'b0;
    logic          Abort = 1'b0;
    logic [AW-1:0] FirstAddr = '0;
    logic [AW-1:0] LastAddr = '0;
    logic          Busy, Done;
    logic [AW:0]   WordCount;
    logic          RamChipEnable, RamWriteEnable;
    logic [AW-1:0] RamAddress;
    logic [WW-1:0] RamWriteData;
    logic [WW-1:0] RamReadData = '0;
    logic          UpdOutValid;
    logic          UpdOutReady = 1'b1;
    logic [WW-1:0] UpdOutWord;
    logic [AW-1:0] UpdOutAddr;
    logic          UpdInValid = 1'b0;
    logic          UpdInReady;
    logic [WW-1:0] UpdInWord = '0;

    neuron_ram_sweeper dut (
        .Clock(Clock), .Reset(Reset), .Start(Start), .Abort(Abort),
        .FirstAddr(FirstAddr), .LastAddr(LastAddr),
        .Busy(Busy), .Done(Done), .WordCount(WordCount),
        .RamChipEnable(RamChipEnable), .RamWriteEnable(RamWriteEnable),
        .RamAddress(RamAddress), .RamWriteData(RamWriteData), .RamReadData(RamReadData),
        .UpdOutValid(UpdOutValid), .UpdOutReady(UpdOutReady),
        .UpdOutWord(UpdOutWord), .UpdOutAddr(UpdOutAddr),
        .UpdInValid(UpdInValid), .UpdInReady(UpdInReady), .UpdInWord(UpdInWord)
    );

    always #5 Clock = ~Clock;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [WW-1:0] got, input logic [WW-1:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    logic [WW-1:0] mem [NA];
    logic [WW-1:0] ref_mem [NA];
    logic [AW-1:0] exp_addr [$];
    logic [WW-1:0] exp_data [$];

    int            cyc = 0;
    int            start_cyc = 0;
    int            done_cyc = 0;
    int            done_cnt = 0;
    int            wr_cyc [NA];
    bit            offered [NA];
    int            last_off_addr = -1;
    bit            pend = 0;
    bit            clr_in = 0;
    logic [WW-1:0] pend_word = '0;
    logic [AW-1:0] stall_addr = '0;
    int            stall_n = 0;
    int            stall_cnt = 0;
    logic [WW-1:0] stall_word = '0;
    int            flush_req = 0;
    int            flush_ack = 0;

    // RAM, update unit and write-back scoreboard, all evaluated mid-cycle
    initial forever begin
        @(negedge Clock);
        cyc++;
        if (flush_ack != flush_req) begin
            flush_ack  = flush_req;
            UpdInValid = 1'b0;
            pend       = 0;
            clr_in     = 0;
        end
        if (RamChipEnable) begin
            if (RamWriteEnable) begin
                mem[RamAddress]    = RamWriteData;
                wr_cyc[RamAddress] = cyc;
                if (exp_addr.size() == 0) begin
                    chk("extra_write", WW'(exp_addr.size()), WW'(1));
                end else begin
                    chk("wr_addr", WW'(RamAddress), WW'(exp_addr.pop_front()));
                    chk("wr_data", RamWriteData, exp_data.pop_front());
                end
            end else begin
                RamReadData = mem[RamAddress];
            end
        end
        if (Done) begin
            done_cnt++;
            done_cyc = cyc;
        end
        if (Start && !Busy && !Reset) start_cyc = cyc;
        if (clr_in) begin
            UpdInValid = 1'b0;
            clr_in     = 0;
        end
        if (pend) begin
            UpdInValid = 1'b1;
            UpdInWord  = pend_word;
            pend       = 0;
        end
        if (UpdOutValid && UpdOutAddr == stall_addr && stall_cnt < stall_n) begin
            UpdOutReady = 1'b0;
            stall_cnt++;
            chk("stall_word", UpdOutWord, stall_word);
            chk("stall_ram_idle", WW'(RamChipEnable), WW'(0));
        end else begin
            UpdOutReady = 1'b1;
        end
        if (UpdOutValid && UpdOutReady) begin
            pend                = 1;
            pend_word           = UpdOutWord + WW'(1);
            last_off_addr       = int'(UpdOutAddr);
            offered[UpdOutAddr] = 1;
        end
        if (UpdInValid && UpdInReady) clr_in = 1;
    end

    // Queue the expected write-backs of a range and advance the reference image
    task automatic push_range(input int f, input int l, output int n);
        int a;
        bit skip;
        a = f;
        n = 0;
        forever begin
            skip = 0;
`ifdef NRC_SKIP_INVALID_EN
            skip = !ref_mem[a][VB];
`endif
            if (!skip) begin
                ref_mem[a] = ref_mem[a] + WW'(1);
                exp_addr.push_back(AW'(a));
                exp_data.push_back(ref_mem[a]);
                n++;
            end
            if (a == l) break;
            a = (a + 1) % NA;
        end
    endtask

    task automatic pulse_start(input int f, input int l);
        FirstAddr = AW'(f);
        LastAddr  = AW'(l);
        Start     = 1'b1;
        @(posedge Clock); #1;
        Start     = 1'b0;
    endtask

    task automatic wait_done(input int d0);
        int k;
        k = 0;
        while (done_cnt == d0 && k < 600) begin
            @(posedge Clock); #1;
            k++;
        end
        chk("done_pulses", WW'(done_cnt - d0), WW'(1));
        @(posedge Clock); #1;
        chk("busy_after", WW'(Busy), WW'(0));
        chk("sb_empty", WW'(exp_addr.size()), WW'(0));
    endtask

    initial begin
        int n, d0, k, mm;
        for (int i = 0; i < NA; i++) begin
            logic [WW-1:0] w;
            w = '0;
            for (int j = 0; j < 10; j++) w = {w[WW-33:0], 32'($urandom())};
            w[VB]      = 1'b1;
            mem[i]     = w;
            ref_mem[i] = w;
            wr_cyc[i]  = 0;
            offered[i] = 0;
        end

        // Start held together with Reset must be ignored
        FirstAddr = 5'd3;
        LastAddr  = 5'd5;
        Start     = 1'b1;
        repeat (3) @(posedge Clock);
        #1;
        Reset = 1'b0;
        Start = 1'b0;
        @(posedge Clock); #1;
        chk("rst_busy", WW'(Busy), WW'(0));
        chk("rst_ctl", WW'({Done, RamChipEnable, RamWriteEnable, UpdOutValid, UpdInReady}), WW'(0));
        chk("rst_wc", WW'(WordCount), WW'(0));
        chk("rst_bus", RamWriteData | UpdOutWord | WW'(RamAddress) | WW'(UpdOutAddr), WW'(0));

        // Plain range, zero-stall update unit
        push_range(3, 5, n);
        d0 = done_cnt;
        pulse_start(3, 5);
        chk("busy_run", WW'(Busy), WW'(1));
        wait_done(d0);
        chk("done_latency", WW'(done_cyc - start_cyc), WW'(16));
        chk("wc_3_5", WW'(WordCount), WW'(n));

        // Wrapping range
        push_range(30, 1, n);
        d0 = done_cnt;
        pulse_start(30, 1);
        wait_done(d0);
        chk("wc_wrap", WW'(WordCount), WW'(4));

        // Update unit stalls four cycles on address 7
        stall_word = ref_mem[7];
        stall_addr = 5'd7;
        stall_n    = 4;
        push_range(6, 8, n);
        d0 = done_cnt;
        pulse_start(6, 8);
        wait_done(d0);
        chk("stall_cycles", WW'(stall_cnt), WW'(4));
        chk("stall_word_time", WW'(wr_cyc[7] - wr_cyc[6]), WW'(9));
        chk("wc_stall", WW'(WordCount), WW'(3));

        // Second Start mid-sweep must not disturb the range
        push_range(10, 11, n);
        d0 = done_cnt;
        pulse_start(10, 11);
        repeat (3) @(posedge Clock);
        #1;
        pulse_start(20, 25);
        wait_done(d0);
        chk("wc_restart", WW'(WordCount), WW'(2));

        // Abort while collecting address 2: only 0 and 1 are written back
        push_range(0, 1, n);
        d0 = done_cnt;
        pulse_start(0, 3);
        k = 0;
        while (!(UpdInReady && last_off_addr == 2) && k < 200) begin
            @(posedge Clock); #1;
            k++;
        end
        chk("abort_reach", WW'(UpdInReady), WW'(1));
        Abort = 1'b1;
        @(posedge Clock); #1;
        Abort = 1'b0;
        chk("abort_busy", WW'(Busy), WW'(0));
        flush_req++;
        repeat (20) @(posedge Clock);
        #1;
        chk("abort_no_done", WW'(done_cnt - d0), WW'(0));
        chk("abort_wc", WW'(WordCount), WW'(2));
        chk("abort_sb", WW'(exp_addr.size()), WW'(0));

        // Word with Valid=0 at address 1
        mem[1][VB]     = 1'b0;
        ref_mem[1][VB] = 1'b0;
        offered[1]     = 0;
        push_range(0, 3, n);
        d0 = done_cnt;
        pulse_start(0, 3);
        wait_done(d0);
`ifdef NRC_SKIP_INVALID_EN
        chk("wc_skip", WW'(WordCount), WW'(3));
        chk("skip_not_offered", WW'(offered[1]), WW'(0));
`else
        chk("wc_noskip", WW'(WordCount), WW'(4));
        chk("noskip_offered", WW'(offered[1]), WW'(1));
`endif

        mm = 0;
        for (int i = 0; i < NA; i++) if (mem[i] !== ref_mem[i]) mm++;
        chk("ram_final", WW'(mm), WW'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule

// File: doc/neuron_ram_sweeper.md
# neuron_ram_sweeper

Initiator-side controller for the single-port neuron state RAM. On a start pulse it sweeps a contiguous address range, reading each neuron word, handing it to the neuron update datapath over a valid/ready handshake, accepting the updated word back and writing it to the same address. It sits between the time-step scheduler (Start/Done) and the neuron RAM and update unit, and is the only agent driving the RAM ports during a sweep.

## Interface
- INTEGER_WIDTH, 16, integer bits of each fixed-point field
- DATA_WIDTH_FRAC, 32, fractional bits of each fixed-point field
- DATA_WIDTH, INTEGER_WIDTH+DATA_WIDTH_FRAC, fixed-point field width
- TREF_WIDTH, 8, refractory counter base width; RefVal field is TREF_WIDTH+3 bits
- NEURON_WIDTH_LOGICAL, 11, NID field width
- WORD_WIDTH, DATA_WIDTH*6+TREF_WIDTH+3+NEURON_WIDTH_LOGICAL+2, RAM word; format MSB→LSB |NID|Valid|Ntype|Vmem|Gex|Gin|RefVal|ExWeight|InWeight|Vth|
- ADDR_WIDTH, 5, RAM address width

- Clock  in  1  rising-edge clock
- Reset  in  1  synchronous, active-high
- Start  in  1  one-cycle pulse, begins sweep; ignored while Busy
- Abort  in  1  terminates sweep; no further RAM access
- FirstAddr, LastAddr  in  ADDR_WIDTH each  inclusive range, latched on accepted Start
- Busy  out  1  high from cycle after accepted Start until Done/abort
- Done  out  1  one-cycle pulse after final write
- WordCount  out  ADDR_WIDTH+1  words written back in current/last sweep
- RamChipEnable, RamWriteEnable  out  1 each  RAM controls
- RamAddress  out  ADDR_WIDTH; RamWriteData  out  WORD_WIDTH
- RamReadData  in  WORD_WIDTH  RAM output, valid the cycle after a read-enable edge
- UpdOutValid  out 1; UpdOutReady  in 1; UpdOutWord  out WORD_WIDTH; UpdOutAddr  out ADDR_WIDTH
- UpdInValid  in 1; UpdInReady  out 1; UpdInWord  in WORD_WIDTH

## Operation
- States: IDLE, READ, CAPTURE, OFFER, COLLECT, WRITE, DONE.
- IDLE: Start=1 latches FirstAddr→Cur, LastAddr→Last, clears WordCount → READ.
- READ: RamChipEnable=1, RamWriteEnable=0, RamAddress=Cur → CAPTURE.
- CAPTURE: RamReadData registered into WordReg → OFFER.
- OFFER: UpdOutValid=1, UpdOutWord=WordReg, UpdOutAddr=Cur; on UpdOutReady → COLLECT. Word/addr held stable while not ready.
- COLLECT: UpdInReady=1; on UpdInValid, UpdInWord→WordReg → WRITE.
- WRITE: RamChipEnable=1, RamWriteEnable=1, RamAddress=Cur, RamWriteData=WordReg; WordCount+1; if Cur==Last → DONE else Cur+1 (mod 2^ADDR_WIDTH) → READ.
- DONE: Done=1 for one cycle → IDLE.
- Range wraps: FirstAddr>LastAddr sweeps through 2^ADDR_WIDTH-1 to 0; FirstAddr==LastAddr processes one word; full range = 2^ADDR_WIDTH words (WordCount needs ADDR_WIDTH+1 bits).
- Abort in any non-IDLE state: outputs of that cycle forced inactive (no RAM write, no handshake completion), next state IDLE, no Done. Abort has priority over all transitions.
- RAM outputs are registered-free combinational decodes of state; RamChipEnable=0 in all other states.

## Timing
- Reset: state IDLE; Busy, Done, RamChipEnable, RamWriteEnable, UpdOutValid, UpdInReady = 0; RamAddress, RamWriteData, UpdOutWord, UpdOutAddr, WordCount = 0.
- Minimum 5 cycles per word (READ, CAPTURE, OFFER, COLLECT, WRITE) with Ready/Valid asserted immediately.
- Handshake transfers on the cycle both valid and ready are high; UpdOutValid never deasserts before transfer.
- Start in same cycle as Reset is ignored. Start while Busy ignored.

## Configuration
- NRC_SKIP_INVALID_EN defined: in CAPTURE, if Valid bit (bit WORD_WIDTH-NEURON_WIDTH_LOGICAL-1) of RamReadData is 0, skip OFFER/COLLECT/WRITE; advance Cur → READ, or → DONE if Cur==Last; WordCount not incremented.
- Undefined: every word in range is offered and written back regardless of Valid.

## Test plan
- Range 3..5, update unit returns word+1 with zero stall → RAM 3..5 incremented, Done at cycle 16 after Start (1+3*5), WordCount=3.
- Range 30..1 (ADDR_WIDTH=5), → addresses 30,31,0,1 written in order, WordCount=4.
- UpdOutReady held low 4 cycles at addr 7 → UpdOutWord/UpdOutAddr stable, no RAM access during stall, per-word time 9 cycles.
- Abort asserted in COLLECT for addr 2 → no write to addr 2, IDLE next cycle, Done never pulses, Busy low.
- Start pulsed again mid-sweep → ignored, range unchanged.
- With NRC_SKIP_INVALID_EN, range 0..3 with addr 1 Valid=0 → addr 1 never offered or written, WordCount=3.
